conv3x3_stream_pe: RTL and testbench
====================================

Name: conv3x3_stream_pe

Overview:
Parametrised 3x3 convolution processing element for the Hard-CNN conv layer, the successor to the fixed 32-column PE. It accepts a row-major pixel stream of runtime-configurable width and height. Two internal line buffers plus a 3x3 window register feed a pipelined 9-tap multiply-accumulate. It emits one "valid"-mode (no padding) output per full window, with optional ReLU and valid/ready backpressure on both sides.

Parameters:
DATA_W, 9, signed pixel width
COEF_W, 9, signed weight width
ACC_W, 22, output width (DATA_W+COEF_W+4; must be >= that)
IMG_W_MAX, 32, maximum row length (line-buffer depth)
IMG_H_MAX, 32, maximum frame height
CNT_W, 6, width of the dimension and counter fields (>= clog2(max(IMG_W_MAX,IMG_H_MAX))+1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; latches img_width/img_height/relu_en
img_width  in  CNT_W  row length, legal 3..IMG_W_MAX
img_height  in  CNT_W  frame rows, legal 3..IMG_H_MAX
relu_en  in  1  clamp negative results to 0
w_we  in  1  weight write strobe
w_addr  in  4  weight index 0..8 = row*3+col (row 0 = top/oldest)
w_data  in  COEF_W  signed weight
in_valid  in  1  pixel valid
in_ready  out  1  pixel accepted when in_valid&in_ready
in_data  in  DATA_W  signed pixel
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid&out_ready
out_data  out  ACC_W  signed result
busy  out  1  high from accepted start until DONE
done  out  1  one-cycle pulse at frame end
cfg_err  out  1  sticky; set on illegal start, cleared by next legal start

Behaviour:
- Interface decided: one clock, clk; reset rst_n synchronous, active-low.
- Reset: all outputs 0; state IDLE; counters, window, pipeline valids 0. Weights reset to 0. Line-buffer contents are not reset.
- FSM: IDLE -> RUN on start with legal dims. Start with illegal dims (<3 or >MAX) sets cfg_err and stays IDLE.
- RUN -> FLUSH when the last pixel (row img_height-1, col img_width-1) is accepted.
- FLUSH -> DONE when the pipeline is empty and out_valid=0. DONE -> IDLE after 1 cycle, with done=1 in that cycle.
- start is ignored outside IDLE.
- Weight writes: accepted only in IDLE; ignored when busy. w_addr > 8 is ignored.
- Pipeline advance: adv = !(out_valid && !out_ready). in_ready = (state==RUN) && adv.
- Accept: col/row counters advance; col wraps at img_width-1 and increments row. The line buffers shift, and the window shifts left, loading a new column {lb1_out, lb0_out, in_data}.
- Window valid at accept when row>=2 && col>=2. Result(r-2,c-2) = sum over i,j of w[i*3+j]*p[r-2+i][c-2+j].
- Latency: window updated at accepting edge E; 9 products (DATA_W+COEF_W signed) registered at E+1; adder tree summed, sign-extended to ACC_W, ReLU applied, registered at E+2 with out_valid=1.
- All pipeline stages hold while adv=0, so no output is dropped or duplicated.
- Outputs per frame: exactly (img_width-2)*(img_height-2), in raster order.
- Row wrap: window columns from the previous row never produce outputs, because col<2 gating suppresses them.
- No overflow is possible with ACC_W >= DATA_W+COEF_W+4. No saturation is applied.
- Reset mid-frame: abandons the frame immediately. Weights return to 0, so they must be reloaded.

Decomposition:
- Package conv_pkg holds: the state enum (IDLE, RUN, FLUSH, DONE), the K=3 constant, the ACC_W derivation function, and the weight-index constants.
- Sub-module conv_line_buffer: a single-row delay line of depth IMG_W_MAX. It has a runtime length, a circular write pointer that wraps at img_width-1, and shift-on-enable. It is instantiated twice, cascaded.

Test Plan:
- 4x4 frame, pixels 1..16, all weights 1, out_ready=1 -> outputs 54, 63, 90, 99 in order; done pulses once; busy then drops.
- Same frame, only w[4]=1 -> outputs 6, 7, 10, 11. Each output appears 2 cycles after accept of pixel (r,c) = (2,2), (2,3), (3,2), (3,3).
- All weights -1, relu_en=1 -> four outputs of 0. With relu_en=0 -> -54, -63, -90, -99.
- 32x3 frame with random stalls: out_ready toggling 50% and in_valid gaps -> 30 outputs matching the reference model; in_ready=0 whenever out_valid&&!out_ready; no drops or duplicates.
- start with img_width=2 -> cfg_err=1, busy=0, no in_ready. A following legal start clears cfg_err.
- Assert rst_n low mid-frame of 5x5 -> next cycle out_valid=0, busy=0, IDLE. Reload weights and run 5x5 frame -> 9 correct outputs.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 streaming convolution PE.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    localparam int K      = 3;
    localparam int N_TAPS = K * K;

    localparam logic [3:0] W_IDX_FIRST  = 4'd0;
    localparam logic [3:0] W_IDX_CENTER = 4'd4;
    localparam logic [3:0] W_IDX_LAST   = 4'd8;

    // Width that holds a 9-tap sum of DATA_W x COEF_W products without overflow.
    function automatic int acc_w_min(input int data_w, input int coef_w);
        return data_w + coef_w + 4;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Single-row delay line with runtime length; dout is the sample written len enables ago.
module conv_line_buffer #(
    parameter int DATA_W    = 9,
    parameter int IMG_W_MAX = 32,
    parameter int CNT_W     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [CNT_W-1:0]  len,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int AW = (IMG_W_MAX > 1) ? $clog2(IMG_W_MAX) : 1;

    logic [DATA_W-1:0] mem [IMG_W_MAX];
    logic [CNT_W-1:0]  ptr;

    assign dout = mem[ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == len - CNT_W'(1)) ? '0 : ptr + CNT_W'(1);
        end
    end

    // Storage is deliberately not reset; rows are overwritten before use.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/conv3x3_stream_pe.sv
// Streaming 3x3 "valid"-mode convolution PE: two line buffers, 3x3 window,
// registered products, registered adder tree with optional ReLU, valid/ready both sides.
module conv3x3_stream_pe #(
    parameter int DATA_W    = 9,
    parameter int COEF_W    = 9,
    parameter int ACC_W     = 22,
    parameter int IMG_W_MAX = 32,
    parameter int IMG_H_MAX = 32,
    parameter int CNT_W     = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_W-1:0]         img_width,
    input  logic [CNT_W-1:0]         img_height,
    input  logic                     relu_en,
    input  logic                     w_we,
    input  logic [3:0]               w_addr,
    input  logic signed [COEF_W-1:0] w_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);
    import conv_pkg::*;

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = acc_w_min(DATA_W, COEF_W);

    state_t                    state;
    logic [CNT_W-1:0]          width_q;
    logic [CNT_W-1:0]          height_q;
    logic [CNT_W-1:0]          col;
    logic [CNT_W-1:0]          row;
    logic                      relu_q;
    logic signed [COEF_W-1:0]  weight [N_TAPS];
    logic signed [DATA_W-1:0]  win    [N_TAPS];
    logic signed [PROD_W-1:0]  prod   [N_TAPS];
    logic                      win_v;
    logic                      prod_v;
    logic                      adv;
    logic                      accept;
    logic                      start_ok;
    logic                      last_px;
    logic                      lb_clr;
    logic [DATA_W-1:0]         lb0_out;
    logic [DATA_W-1:0]         lb1_out;
    logic signed [SUM_W-1:0]   sum;
    logic signed [ACC_W-1:0]   result;

    assign adv      = !(out_valid && !out_ready);
    assign in_ready = (state == RUN) && adv;
    assign accept   = in_valid && in_ready;
    assign last_px  = (row == height_q - CNT_W'(1)) && (col == width_q - CNT_W'(1));
    assign lb_clr   = (state == IDLE);
    assign start_ok = (img_width  >= CNT_W'(3)) && (img_width  <= CNT_W'(IMG_W_MAX)) &&
                      (img_height >= CNT_W'(3)) && (img_height <= CNT_W'(IMG_H_MAX));

    conv_line_buffer #(
        .DATA_W    (DATA_W),
        .IMG_W_MAX (IMG_W_MAX),
        .CNT_W     (CNT_W)
    ) u_lb0 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (lb_clr),
        .en    (accept),
        .len   (width_q),
        .din   (in_data),
        .dout  (lb0_out)
    );

    conv_line_buffer #(
        .DATA_W    (DATA_W),
        .IMG_W_MAX (IMG_W_MAX),
        .CNT_W     (CNT_W)
    ) u_lb1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (lb_clr),
        .en    (accept),
        .len   (width_q),
        .din   (lb0_out),
        .dout  (lb1_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            width_q  <= '0;
            height_q <= '0;
            relu_q   <= 1'b0;
            col      <= '0;
            row      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            width_q  <= img_width;
                            height_q <= img_height;
                            relu_q   <= relu_en;
                            col      <= '0;
                            row      <= '0;
                            cfg_err  <= 1'b0;
                            busy     <= 1'b1;
                            state    <= RUN;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_px) begin
                            state <= FLUSH;
                        end
                        if (col == width_q - CNT_W'(1)) begin
                            col <= '0;
                            row <= row + CNT_W'(1);
                        end else begin
                            col <= col + CNT_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (!win_v && !prod_v && !out_valid) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                weight[i] <= '0;
            end
        end else if (w_we && (state == IDLE) && (w_addr <= W_IDX_LAST)) begin
            weight[w_addr] <= w_data;
        end
    end

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < N_TAPS; i++) begin
            sum = sum + SUM_W'(prod[i]);
        end
        result = ACC_W'(sum);
        if (relu_q && (result < 0)) begin
            result = '0;
        end
    end

    // Every stage freezes together while the output is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_v     <= 1'b0;
            prod_v    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                win[i]  <= '0;
                prod[i] <= '0;
            end
        end else if (adv) begin
            win_v <= accept && (row >= CNT_W'(2)) && (col >= CNT_W'(2));
            if (accept) begin
                for (int unsigned r = 0; r < K; r++) begin
                    win[r*K]   <= win[r*K+1];
                    win[r*K+1] <= win[r*K+2];
                end
                win[2] <= lb1_out;
                win[5] <= lb0_out;
                win[8] <= in_data;
            end
            prod_v <= win_v;
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                prod[i] <= PROD_W'(win[i]) * PROD_W'(weight[i]);
            end
            out_valid <= prod_v;
            if (prod_v) begin
                out_data <= result;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream_pe.sv
// Self-checking bench for conv3x3_stream_pe against a direct-convolution reference.
module tb_conv3x3_stream_pe;

    localparam int DW = 9;
    localparam int CW = 9;
    localparam int AW = 22;
    localparam int NW = 6;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [NW-1:0]        img_width;
    logic [NW-1:0]        img_height;
    logic                 relu_en;
    logic                 w_we;
    logic [3:0]           w_addr;
    logic signed [CW-1:0] w_data;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [AW-1:0] out_data;
    logic                 busy;
    logic                 done;
    logic                 cfg_err;

    conv3x3_stream_pe #(
        .DATA_W    (DW),
        .COEF_W    (CW),
        .ACC_W     (AW),
        .IMG_W_MAX (32),
        .IMG_H_MAX (32),
        .CNT_W     (NW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .img_width  (img_width),
        .img_height (img_height),
        .relu_en    (relu_en),
        .w_we       (w_we),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pix [32][32];
    int wts [9];
    int exp_q [$];
    int got [$];
    int got_cyc [$];
    int acc_cyc [1024];
    int pix_cnt = 0;
    int done_cnt = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output scoreboard, accept timestamps and stall-propagation check.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (in_valid && in_ready) begin
            if (pix_cnt < 1024) acc_cyc[pix_cnt] = cyc;
            pix_cnt++;
        end
        if (out_valid && !out_ready) begin
            check("in_ready_during_stall", int'(in_ready), 0);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", int'(out_data), -999999);
            end else begin
                check("out_data", int'(out_data), exp_q.pop_front());
            end
            got.push_back(int'(out_data));
            got_cyc.push_back(cyc);
        end
    end

    task automatic build_model(input int w, input int h, input bit relu);
        exp_q.delete();
        for (int r = 0; r <= h - 3; r++) begin
            for (int c = 0; c <= w - 3; c++) begin
                int s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += wts[i*3+j] * pix[r+i][c+j];
                if (relu && s < 0) s = 0;
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic load_weights();
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            w_we = 1'b1; w_addr = 4'(i); w_data = CW'(wts[i]);
        end
        @(posedge clk); #1;
        w_we = 1'b0;
    endtask

    task automatic pulse_start(input int w, input int h, input bit relu);
        @(posedge clk); #1;
        start = 1'b1; img_width = NW'(w); img_height = NW'(h); relu_en = relu;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Leaves the caller at posedge+1 with in_valid low.
    task automatic feed(input int w, input int n, input bit gaps);
        int k;
        for (int idx = 0; idx < n; idx++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = DW'(pix[idx / w][idx % w]);
            k = 0;
            @(negedge clk);
            while (!in_ready && k < 300) begin
                @(negedge clk);
                k++;
            end
            if (k >= 300) check("in_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int w, input int h, input bit relu,
                             input bit gaps, input bit rr);
        int d0;
        int k;
        build_model(w, h, relu);
        got.delete();
        got_cyc.delete();
        pix_cnt = 0;
        d0 = done_cnt;
        pulse_start(w, h, relu);
        @(negedge clk);
        check("busy_after_start", int'(busy), 1);
        check("cfg_err_after_start", int'(cfg_err), 0);
        @(posedge clk); #1;
        rand_ready = rr;
        feed(w, w * h, gaps);
        k = 0;
        while (done_cnt == d0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) check("done_timeout", 0, 1);
        rand_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_after_done", int'(busy), 0);
        check("done_pulses", done_cnt - d0, 1);
        check("missing_outputs", exp_q.size(), 0);
        check("output_count", got.size(), (w - 2) * (h - 2));
    endtask

    task automatic fill_ramp(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                pix[r][c] = r * w + c + 1;
    endtask

    task automatic set_all_weights(input int v);
        for (int i = 0; i < 9; i++) wts[i] = v;
    endtask

    initial begin
        int lit [4];
        rst_n = 1'b0; start = 1'b0; img_width = '0; img_height = '0; relu_en = 1'b0;
        w_we = 1'b0; w_addr = '0; w_data = '0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        check("rst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 4x4 ramp, all weights 1
        fill_ramp(4, 4);
        set_all_weights(1);
        load_weights();
        run_frame(4, 4, 1'b0, 1'b0, 1'b0);
        lit = '{54, 63, 90, 99};
        for (int i = 0; i < 4; i++) check("lit_sum_all_ones", got[i], lit[i]);

        // centre tap only, with output latency relative to the accepting pixel
        set_all_weights(0);
        wts[4] = 1;
        load_weights();
        run_frame(4, 4, 1'b0, 1'b0, 1'b0);
        lit = '{6, 7, 10, 11};
        for (int i = 0; i < 4; i++) begin
            check("lit_centre", got[i], lit[i]);
            check("latency", got_cyc[i] - acc_cyc[(i / 2 + 2) * 4 + (i % 2) + 2], 3);
        end

        // all weights -1 with and without ReLU
        set_all_weights(-1);
        load_weights();
        run_frame(4, 4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check("lit_relu", got[i], 0);
        run_frame(4, 4, 1'b0, 1'b0, 1'b0);
        lit = '{-54, -63, -90, -99};
        for (int i = 0; i < 4; i++) check("lit_neg", got[i], lit[i]);

        // 32x3 random data with input gaps and output backpressure
        for (int i = 0; i < 9; i++) wts[i] = $urandom_range(0, 511) - 256;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 32; c++)
                pix[r][c] = $urandom_range(0, 511) - 256;
        load_weights();
        run_frame(32, 3, 1'b0, 1'b1, 1'b1);

        // illegal width, then a legal start clears the error
        pulse_start(2, 4, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        check("cfg_err_set", int'(cfg_err), 1);
        check("cfg_err_busy", int'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("cfg_err_in_ready", int'(in_ready), 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        fill_ramp(4, 4);
        set_all_weights(1);
        load_weights();
        run_frame(4, 4, 1'b0, 1'b0, 1'b0);

        // reset part-way through a 5x5 frame, then reload and rerun
        fill_ramp(5, 5);
        wts = '{-1, 0, 2, 0, 3, 0, 1, -2, 1};
        load_weights();
        exp_q.delete();
        pulse_start(5, 5, 1'b0);
        feed(5, 12, 1'b0);
        in_valid = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        load_weights();
        run_frame(5, 5, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule
